// File: rtl/dds_cfg_sequencer.sv
// dds_cfg_sequencer
//   Captures a DDS configuration (frequency, waveform, amplitude, sweep
//   settings) on the rising edge of spi_ok. The configuration is applied at
//   the next phase-accumulator wrap, or after WRAP_TIMEOUT cycles if no wrap
//   arrives. It can optionally run a linear frequency sweep from the captured
//   frequency up to sweep_stop.
//
//   Build option: define DDS_SWEEP_LOOP_EN to make the sweep restart from the
//   start frequency after reaching the stop frequency. Without it, the sweep
//   ends in RUN holding the stop frequency.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   spi_ok               SPI transfer-complete level (rising edge = capture)
//   freq_in/wave_in/amp_in  configuration to capture
//   sweep_en/sweep_stop/sweep_step/dwell  sweep request and parameters
//   phase_wrap           one-cycle accumulator wrap pulse
//   fre_dat/pic_dat/amp_dat  applied configuration
//   cfg_upd              one-cycle pulse following any output change
//   busy                 high while pending or sweeping
//   sweep_active         high while sweeping
module dds_cfg_sequencer #(
    parameter int unsigned FW           = 24,
    parameter int unsigned WW           = 8,
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned WRAP_TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_ok,
    input  logic [FW-1:0] freq_in,
    input  logic [WW-1:0] wave_in,
    input  logic [AW-1:0] amp_in,
    input  logic          sweep_en,
    input  logic [FW-1:0] sweep_stop,
    input  logic [FW-1:0] sweep_step,
    input  logic [DW-1:0] dwell,
    input  logic          phase_wrap,
    output logic [FW-1:0] fre_dat,
    output logic [WW-1:0] pic_dat,
    output logic [AW-1:0] amp_dat,
    output logic          cfg_upd,
    output logic          busy,
    output logic          sweep_active
);

    localparam int unsigned TW = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(WRAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RUN,
        SWEEP
    } state_t;

    state_t state;

    logic          spi_ok_q;
    logic [FW-1:0] sh_freq;
    logic [WW-1:0] sh_wave;
    logic [AW-1:0] sh_amp;
    logic          sh_sweep;
    logic [FW-1:0] sh_stop;
    logic [FW-1:0] sh_step;
    logic [DW-1:0] sh_dwell;
    logic [TW-1:0] to_cnt;
    logic [DW-1:0] dw_cnt;

    logic          capture;
    logic          apply_go;
    logic          sweep_go;
    logic          dwell_done;
    logic [DW-1:0] dw_last;
    logic [FW:0]   step_sum;

    always_comb begin
        capture    = spi_ok & ~spi_ok_q;
        apply_go   = phase_wrap || (to_cnt == TO_LAST);
        sweep_go   = sh_sweep && (sh_step != '0) && (sh_stop > sh_freq);
        // A dwell of 0 behaves like 1: step every cycle.
        dw_last    = (sh_dwell == '0) ? '0 : sh_dwell - DW'(1);
        dwell_done = (dw_cnt == dw_last);
        // One extra bit so a step near the top of the range cannot wrap.
        step_sum   = {1'b0, fre_dat} + {1'b0, sh_step};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            spi_ok_q     <= 1'b0;
            sh_freq      <= '0;
            sh_wave      <= '0;
            sh_amp       <= '0;
            sh_sweep     <= 1'b0;
            sh_stop      <= '0;
            sh_step      <= '0;
            sh_dwell     <= '0;
            to_cnt       <= '0;
            dw_cnt       <= '0;
            fre_dat      <= '0;
            pic_dat      <= '0;
            amp_dat      <= '0;
            cfg_upd      <= 1'b0;
            busy         <= 1'b0;
            sweep_active <= 1'b0;
        end else begin
            spi_ok_q <= spi_ok;
            cfg_upd  <= 1'b0;

            // A capture wins over everything else, including a wrap on the
            // same edge and any sweep step that would have occurred.
            if (capture) begin
                sh_freq      <= freq_in;
                sh_wave      <= wave_in;
                sh_amp       <= amp_in;
                sh_sweep     <= sweep_en;
                sh_stop      <= sweep_stop;
                sh_step      <= sweep_step;
                sh_dwell     <= dwell;
                to_cnt       <= '0;
                state        <= PEND;
                busy         <= 1'b1;
                sweep_active <= 1'b0;
            end else begin
                case (state)
                    PEND: begin
                        if (apply_go) begin
                            fre_dat <= sh_freq;
                            pic_dat <= sh_wave;
                            amp_dat <= sh_amp;
                            cfg_upd <= 1'b1;
                            dw_cnt  <= '0;
                            if (sweep_go) begin
                                state        <= SWEEP;
                                busy         <= 1'b1;
                                sweep_active <= 1'b1;
                            end else begin
                                state        <= RUN;
                                busy         <= 1'b0;
                                sweep_active <= 1'b0;
                            end
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end

                    SWEEP: begin
                        if (dwell_done) begin
                            dw_cnt  <= '0;
                            cfg_upd <= 1'b1;
`ifdef DDS_SWEEP_LOOP_EN
                            // Sitting at stop: this expiry restarts the ramp.
                            if (fre_dat == sh_stop) begin
                                fre_dat <= sh_freq;
                            end else if (step_sum >= {1'b0, sh_stop}) begin
                                fre_dat <= sh_stop;
                            end else begin
                                fre_dat <= step_sum[FW-1:0];
                            end
`else
                            if (step_sum >= {1'b0, sh_stop}) begin
                                fre_dat      <= sh_stop;
                                state        <= RUN;
                                busy         <= 1'b0;
                                sweep_active <= 1'b0;
                            end else begin
                                fre_dat <= step_sum[FW-1:0];
                            end
`endif
                        end else begin
                            dw_cnt <= dw_cnt + DW'(1);
                        end
                    end

                    default: begin
                        // IDLE and RUN hold the applied configuration.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dds_cfg_sequencer.md
Name: dds_cfg_sequencer

Overview:
- Sits between the SPI slave register file and the DDS output datapath.
- Captures frequency, waveform and amplitude settings when an SPI transfer completes.
- Applies them glitch-free at the next phase-accumulator wrap, with a timeout fallback if no wrap arrives.
- Optionally runs a linear frequency sweep from the captured frequency to a stop frequency.

Parameters:
- FW, 24: frequency word width.
- WW, 8: waveform select width.
- AW, 16: amplitude word width.
- DW, 16: dwell counter width.
- WRAP_TIMEOUT, 4096: maximum cycles to wait for phase_wrap before forcing the update.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_ok  in  1  SPI transfer-complete level; rising edge triggers a capture.
- freq_in  in  FW  frequency word, or sweep start frequency.
- wave_in  in  WW  waveform select.
- amp_in  in  AW  amplitude word.
- sweep_en  in  1  request a sweep for this configuration.
- sweep_stop  in  FW  sweep end frequency.
- sweep_step  in  FW  frequency increment per dwell period.
- dwell  in  DW  cycles per sweep step; 0 is treated as 1.
- phase_wrap  in  1  one-cycle pulse from the DDS accumulator wrap.
- fre_dat  out  FW  applied frequency word.
- pic_dat  out  WW  applied waveform select.
- amp_dat  out  AW  applied amplitude word.
- cfg_upd  out  1  one-cycle pulse after any output change.
- busy  out  1  high in PEND or SWEEP.
- sweep_active  out  1  high in SWEEP.

Behaviour:
- Reset: fre_dat, pic_dat, amp_dat = 0; cfg_upd, busy, sweep_active = 0; spi_ok history register = 0; state IDLE.
- FSM states: IDLE, PEND, RUN, SWEEP.
- Edge detect: spi_ok_q <= spi_ok. A capture occurs at any edge where spi_ok=1 and spi_ok_q=0.
  - A capture loads the shadow registers with all inputs, clears the timeout counter and enters PEND, from any state.
  - spi_ok held high yields exactly one capture.
- PEND: the timeout counter increments every cycle. Apply happens at the first edge where either condition holds:
  - phase_wrap=1, or
  - counter == WRAP_TIMEOUT-1.
- Apply edge:
  - fre_dat/pic_dat/amp_dat load from the shadow registers.
  - cfg_upd=1 for the following cycle.
  - Next state is SWEEP if shadow sweep_en=1, step!=0 and stop>start; otherwise RUN.
- Capture-cycle wrap: phase_wrap on the same edge as a capture is ignored.
- Capture in PEND: overwrites the shadow registers and restarts the timeout; the outputs keep their old values.
- Outputs never change except on apply or on a sweep step.
- SWEEP:
  - Dwell counter starts at 0 on entry and increments each cycle.
  - At count == max(dwell,1)-1, the counter returns to 0 and a step occurs.
  - Step arithmetic uses FW+1-bit sum = fre_dat + step.
  - If sum >= stop: fre_dat = stop and the end-of-sweep action applies (see Optional Feature).
  - Otherwise fre_dat = sum.
  - Each step pulses cfg_upd the following cycle.
  - Steps are not gated by phase_wrap.
- Capture during SWEEP aborts the sweep: state becomes PEND, sweep_active drops next cycle, fre_dat holds its current value until apply.
- RUN/IDLE: hold outputs; busy=0.
- No overflow: fre_dat never exceeds stop; the FW+1-bit sum prevents wrap at 0xFFFFFF.

Optional Feature:
- Macro: DDS_SWEEP_LOOP_EN.
- Defined: when fre_dat reaches stop, the next dwell expiry reloads the shadow start frequency and the sweep continues indefinitely, with cfg_upd on the reload. Only a capture or reset leaves SWEEP.
- Undefined: reaching stop moves the FSM to RUN on that edge; sweep_active=0 and fre_dat=stop thereafter.

Test Plan:
1. Reset asserted mid-sweep (fre_dat=160) -> all outputs 0 immediately; state IDLE; no cfg_upd after release.
2. Capture with freq_in=0x001000, wave_in=2, amp_in=0x8000, sweep_en=0; phase_wrap 10 cycles later -> outputs update on that wrap edge; cfg_upd high exactly 1 cycle; busy high for the 10 cycles, then low.
3. WRAP_TIMEOUT=16, capture, no phase_wrap -> apply on the 16th edge after capture; phase_wrap coincident with the capture edge is ignored.
4. sweep_en=1, start=100, step=30, stop=200, dwell=4 -> fre_dat 100,130,160,190,200 spaced 4 cycles with cfg_upd on each.
   - Macro off: RUN and sweep_active=0 after 200.
   - Macro on: 100 four cycles after 200, and the sweep repeats.
5. Capture at fre_dat=160 during a sweep, new freq 0x000500, then phase_wrap 5 cycles later -> fre_dat holds 160 for those 5 cycles, then 0x000500; sweep_active=0.
6. spi_ok held high 50 cycles, with a second capture (new freq) in PEND before any wrap -> a single apply, carrying the second values; dwell=0 with sweep -> a step every cycle.
